// File: rtl/lcd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lcd_ctrl_pkg
// Shared types and constants for the HD44780 write-only LCD controller.
//   lcd_entry_t  : one queued LCD write {on, rs, data[7:0]}
//   lcd_state_e  : controller FSM states (debug view)
//   ST_*         : the same state codes as plain 3-bit constants
//   INIT_CMDS    : power-on command sequence (used with LCD_CTRL_INIT_EN)
// -----------------------------------------------------------------------------
package lcd_ctrl_pkg;

    typedef struct packed {
        logic       on;
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    typedef enum logic [2:0] {
        LCD_IDLE      = 3'd0,
        LCD_INIT_WAIT = 3'd1,
        LCD_INIT_CMD  = 3'd2,
        LCD_SETUP     = 3'd3,
        LCD_PULSE     = 3'd4,
        LCD_HOLD      = 3'd5,
        LCD_EXEC      = 3'd6
    } lcd_state_e;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT_WAIT = 3'd1;
    localparam logic [2:0] ST_INIT_CMD  = 3'd2;
    localparam logic [2:0] ST_SETUP     = 3'd3;
    localparam logic [2:0] ST_PULSE     = 3'd4;
    localparam logic [2:0] ST_HOLD      = 3'd5;
    localparam logic [2:0] ST_EXEC      = 3'd6;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    // Element [0] is issued first.
    localparam int INIT_CMD_NUM = 4;
    localparam logic [3:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_long_cmd(input lcd_entry_t e);
        return !e.rs && (e.data inside {8'h01, 8'h02, 8'h03});
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// lcd_fifo
// Single-clock synchronous FIFO of lcd_entry_t.
//   clk, rst_n   : clock, synchronous active-low reset (empties the FIFO)
//   push, wr_entry : enqueue wr_entry when push=1 and not full
//   pop, rd_entry  : rd_entry shows the head; pop=1 and not empty dequeues it
//   full, empty  : status from the registered pointers
// Handshake: push is a strobe with no back-pressure; full acts as "not ready"
// and a push while full is simply ignored here (the caller flags overflow).
// Pop and push in the same cycle while full: only the pop happens.
// -----------------------------------------------------------------------------
module lcd_fifo
    import lcd_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  lcd_entry_t wr_entry,
    input  logic       pop,
    output lcd_entry_t rd_entry,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    lcd_entry_t  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
// Write-only HD44780 character-LCD controller. Store strobes are queued in a
// FIFO and replayed on the LCD pins with setup, enable pulse, hold and
// execution timing.
// Optional feature: define LCD_CTRL_INIT_EN to run the power-on wait and the
// 0x38/0x0C/0x01/0x06 init sequence after reset.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_lcd_data     : store word, [31]=ON, [9]=RS, [7:0]=byte
//   i_lcd_vld      : one-cycle write strobe
//   o_lcd_data     : LCD DB[7:0]
//   o_lcd_rs       : register select
//   o_lcd_rw       : tied 0 (write-only)
//   o_lcd_en       : enable strobe
//   o_lcd_on       : display power/backlight
//   o_busy         : FIFO non-empty or FSM not idle
//   o_full         : FIFO full
//   o_overflow     : sticky, a write was dropped because the FIFO was full
//   o_dbg_state    : current FSM state
// Handshake: i_lcd_vld has no ready; o_full is the only flow indication and a
// strobe while o_full=1 is dropped and recorded in o_overflow.
// -----------------------------------------------------------------------------
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETUP_CYC     = 4,
    parameter int EN_CYC        = 16,
    parameter int HOLD_CYC      = 4,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 80000,
    parameter int INIT_WAIT_CYC = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_data,
    input  logic        i_lcd_vld,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_full,
    output logic        o_overflow,
    output lcd_state_e  o_dbg_state
);

    localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, EN_CYC),
                                             max_int(HOLD_CYC, EXEC_CYC)),
                                     max_int(LONG_EXEC_CYC, INIT_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

`ifdef LCD_CTRL_INIT_EN
    localparam logic [CNT_W-1:0] INIT_WAIT_LD = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [2:0]       RESET_STATE  = ST_INIT_WAIT;
`else
    localparam logic [2:0]       RESET_STATE  = ST_IDLE;
`endif

    logic [2:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic             rs_q;
    logic             on_q;
    logic [7:0]       data_q;
    logic             long_q;
    logic             ovf_q;

`ifdef LCD_CTRL_INIT_EN
    logic [2:0]       init_idx_q;
    lcd_entry_t       init_entry;
    assign init_entry = '{on: 1'b1, rs: 1'b0, data: INIT_CMDS[init_idx_q[1:0]]};
`endif

    lcd_entry_t wr_entry;
    lcd_entry_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       unused_bits;

    assign wr_entry    = '{on: i_lcd_data[31], rs: i_lcd_data[9], data: i_lcd_data[7:0]};
    assign unused_bits = ^{i_lcd_data[30:10], i_lcd_data[8]};

    // The head is only consumed from IDLE, so the FIFO is never popped
    // while a transfer (or the init sequence) is in flight.
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    lcd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (i_lcd_vld),
        .wr_entry (wr_entry),
        .pop      (fifo_pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Single down-counter: loaded with (length-1) on state entry, the state
    // advances on the cycle the counter reads zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            on_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef LCD_CTRL_INIT_EN
            init_idx_q <= 3'd0;
`endif
        end else begin
            if (i_lcd_vld && fifo_full) begin
                ovf_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        on_q    <= head.on;
                        rs_q    <= head.rs;
                        data_q  <= head.data;
                        long_q  <= is_long_cmd(head);
                        cnt_q   <= SETUP_LD;
                        state_q <= ST_SETUP;
                    end
                end
`ifdef LCD_CTRL_INIT_EN
                // Power-on wait counts up from the reset value of zero.
                ST_INIT_WAIT: begin
                    if (cnt_q == INIT_WAIT_LD) begin
                        cnt_q   <= '0;
                        state_q <= ST_INIT_CMD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_INIT_CMD: begin
                    on_q       <= init_entry.on;
                    rs_q       <= init_entry.rs;
                    data_q     <= init_entry.data;
                    long_q     <= is_long_cmd(init_entry);
                    init_idx_q <= init_idx_q + 3'd1;
                    cnt_q      <= SETUP_LD;
                    state_q    <= ST_SETUP;
                end
`endif
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b1;
                        cnt_q   <= EN_LD;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        cnt_q   <= HOLD_LD;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= long_q ? LONG_LD : EXEC_LD;
                        state_q <= ST_EXEC;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
`ifdef LCD_CTRL_INIT_EN
                        state_q <= (init_idx_q == 3'(INIT_CMD_NUM)) ? ST_IDLE : ST_INIT_CMD;
`else
                        state_q <= ST_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_lcd_data  = data_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en_q;
    assign o_lcd_on    = on_q;
    assign o_busy      = !fifo_empty || (state_q != ST_IDLE);
    assign o_full      = fifo_full;
    assign o_overflow  = ovf_q;
    assign o_dbg_state = lcd_state_e'(state_q);

endmodule

// File: tb/tb_lcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl
// Bench for lcd_ctrl with shortened execution times. Covers reset values,
// single-write timing for a table of command/data words, FIFO overflow with
// back-to-back strobes, reset during an enable pulse and, when
// LCD_CTRL_INIT_EN is defined, the power-on init sequence.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl;
    import lcd_ctrl_pkg::*;

    localparam int FIFO_DEPTH    = 8;
    localparam int SETUP_CYC     = 4;
    localparam int EN_CYC        = 16;
    localparam int HOLD_CYC      = 4;
    localparam int EXEC_CYC      = 40;
    localparam int LONG_EXEC_CYC = 300;
    localparam int INIT_WAIT_CYC = 100;
    localparam int PERIOD_S      = 1 + SETUP_CYC + EN_CYC + HOLD_CYC + EXEC_CYC;
    localparam int PERIOD_L      = 1 + SETUP_CYC + EN_CYC + HOLD_CYC + LONG_EXEC_CYC;

`ifdef LCD_CTRL_INIT_EN
    localparam logic BUSY_IN_RESET = 1'b1;
`else
    localparam logic BUSY_IN_RESET = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_word = 32'h0;
    logic        lcd_vld = 1'b0;
    logic [7:0]  lcd_dout;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic        busy;
    logic        full;
    logic        overflow;
    lcd_state_e  dbg_state;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .SETUP_CYC     (SETUP_CYC),
        .EN_CYC        (EN_CYC),
        .HOLD_CYC      (HOLD_CYC),
        .EXEC_CYC      (EXEC_CYC),
        .LONG_EXEC_CYC (LONG_EXEC_CYC),
        .INIT_WAIT_CYC (INIT_WAIT_CYC)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_lcd_data  (lcd_word),
        .i_lcd_vld   (lcd_vld),
        .o_lcd_data  (lcd_dout),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_en    (lcd_en),
        .o_lcd_on    (lcd_on),
        .o_busy      (busy),
        .o_full      (full),
        .o_overflow  (overflow),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_pass = 0;
    int         pulse_cnt = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Pin monitor: every completed EN pulse is one LCD write; its pins are
    // compared against the head of the expected queue.
    initial begin : monitor
        int   width;
        logic en_prev;
        width = 0;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                width = 0;
                en_prev = 1'b0;
            end else begin
                if (lcd_en) width++;
                if (en_prev && !lcd_en) begin
                    pulse_cnt++;
                    check("en_width", width, EN_CYC);
                    check("rw_low", {31'h0, lcd_rw}, 32'h0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_extra_pulse: got pins 0x%0h, expected no pulse",
                                 {lcd_on, lcd_rs, lcd_dout});
                    end else begin
                        check("sb_pins", {22'h0, lcd_on, lcd_rs, lcd_dout}, {22'h0, exp_q.pop_front()});
                    end
                    width = 0;
                end
                en_prev = lcd_en;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'h0, busy}, 32'h0);
    endtask

    // One strobe into an idle controller; timing measured in edges after the
    // edge that sampled the strobe (E0).
    task automatic run_single(input int idx, input logic [31:0] word,
                              input logic [9:0] pins, input bit long_exec);
        int rise_k, fall_k, idle_k, x;
        x = long_exec ? LONG_EXEC_CYC : EXEC_CYC;
        rise_k = -1;
        fall_k = -1;
        idle_k = -1;
        @(negedge clk);
        lcd_word = word;
        lcd_vld = 1'b1;
        exp_q.push_back(pins);
        @(negedge clk);
        lcd_vld = 1'b0;
        lcd_word = $urandom;
        check($sformatf("v%0d_busy_after_push", idx), {31'h0, busy}, 32'h1);
        for (int k = 1; k <= PERIOD_L + 50 && idle_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) check($sformatf("v%0d_pins", idx), {22'h0, lcd_on, lcd_rs, lcd_dout}, {22'h0, pins});
            if (rise_k < 0 && lcd_en) rise_k = k;
            if (rise_k >= 0 && fall_k < 0 && !lcd_en) fall_k = k;
            if (!busy) idle_k = k;
        end
        check($sformatf("v%0d_en_rise", idx), rise_k, 1 + SETUP_CYC);
        check($sformatf("v%0d_en_fall", idx), fall_k, 1 + SETUP_CYC + EN_CYC);
        check($sformatf("v%0d_busy_drop", idx), idle_k, 1 + SETUP_CYC + EN_CYC + HOLD_CYC + x);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [9:0]  pins;
        bit          long_exec;
    } vec_t;

    vec_t vecs[9];

    // ---------------- test ----------------
    initial begin : main
        int p0;

        vecs[0] = '{32'h8000_0241, 10'h341, 1'b0};   // 'A', RS=1, ON=1
        vecs[1] = '{32'h0000_0001, 10'h001, 1'b1};   // clear
        vecs[2] = '{32'h0000_0201, 10'h101, 1'b0};   // 0x01 as data
        vecs[3] = '{32'h8000_0002, 10'h202, 1'b1};   // home
        vecs[4] = '{32'h0000_0003, 10'h003, 1'b1};   // home (alt code)
        vecs[5] = '{32'h0000_0004, 10'h004, 1'b0};   // entry mode
        vecs[6] = '{32'h0000_0000, 10'h000, 1'b0};
        vecs[7] = '{32'hFFFF_FDFF, 10'h2FF, 1'b0};   // junk bits ignored
        vecs[8] = '{32'h7FFF_FE03, 10'h103, 1'b0};   // 0x03 as data

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_en", {31'h0, lcd_en}, 32'h0);
        check("rst_pins", {22'h0, lcd_on, lcd_rs, lcd_dout}, 32'h0);
        check("rst_rw", {31'h0, lcd_rw}, 32'h0);
        check("rst_busy", {31'h0, busy}, {31'h0, BUSY_IN_RESET});
        check("rst_full", {31'h0, full}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);

`ifdef LCD_CTRL_INIT_EN
        // Init sequence, with a user byte pushed while it runs
        begin
            int rise_k;
            rise_k = -1;
            exp_q.push_back(10'h238);
            exp_q.push_back(10'h20C);
            exp_q.push_back(10'h201);
            exp_q.push_back(10'h206);
            exp_q.push_back(10'h355);
            rst_n = 1'b1;
            for (int k = 1; k <= INIT_WAIT_CYC + SETUP_CYC + 20; k++) begin
                @(negedge clk);
                if (k == 1) check("init_busy_start", {31'h0, busy}, 32'h1);
                if (k == 10) begin
                    lcd_word = 32'h8000_0255;
                    lcd_vld = 1'b1;
                end
                if (k == 11) lcd_vld = 1'b0;
                if (k == INIT_WAIT_CYC) check("init_busy_wait", {31'h0, busy}, 32'h1);
                if (rise_k < 0 && lcd_en) rise_k = k;
            end
            check("init_first_rise", rise_k, INIT_WAIT_CYC + 1 + SETUP_CYC);
            wait_idle("init_idle", 4 * PERIOD_S + PERIOD_L + 2 * PERIOD_S + 50);
            check("init_sb_empty", exp_q.size(), 0);
        end
`else
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // Single writes from the table
        for (int i = 0; i < 9; i++) begin
            run_single(i, vecs[i].word, vecs[i].pins, vecs[i].long_exec);
        end
        check("vec_sb_empty", exp_q.size(), 0);

        // Overflow: FSM busy with A, then nine back-to-back strobes
        p0 = pulse_cnt;
        @(negedge clk);
        lcd_word = 32'h8000_0241;
        lcd_vld = 1'b1;
        exp_q.push_back(10'h341);
        @(negedge clk);
        lcd_vld = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                check("ovf_full_at_8", {31'h0, full}, 32'h1);
                check("ovf_clear_at_8", {31'h0, overflow}, 32'h0);
            end
            lcd_word = {i[0], 21'h0, 1'b1, 1'b0, 8'h30 + 8'(i)};
            lcd_vld = 1'b1;
            if (i < 8) exp_q.push_back({i[0], 1'b1, 8'h30 + 8'(i)});
            @(negedge clk);
        end
        lcd_vld = 1'b0;
        check("ovf_set", {31'h0, overflow}, 32'h1);
        check("ovf_still_full", {31'h0, full}, 32'h1);
        wait_idle("ovf_drain", 10 * PERIOD_S + 50);
        check("ovf_pulses", pulse_cnt - p0, 9);
        check("ovf_sb_empty", exp_q.size(), 0);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);

        // Reset during PULSE with more entries queued
        @(negedge clk);
        lcd_word = 32'h8000_0248;
        lcd_vld = 1'b1;
        exp_q.push_back(10'h348);
        @(negedge clk);
        lcd_word = 32'h8000_0249;
        @(negedge clk);
        lcd_word = 32'h8000_024A;
        @(negedge clk);
        lcd_vld = 1'b0;
        for (int k = 0; k < 40 && !lcd_en; k++) @(negedge clk);
        check("rst_mid_in_pulse", {31'h0, lcd_en}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("rst_mid_en", {31'h0, lcd_en}, 32'h0);
        check("rst_mid_pins", {22'h0, lcd_on, lcd_rs, lcd_dout}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, {31'h0, BUSY_IN_RESET});
        check("rst_mid_full", {31'h0, full}, 32'h0);
        check("rst_mid_ovf", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulse_cnt;
`ifdef LCD_CTRL_INIT_EN
        exp_q.push_back(10'h238);
        exp_q.push_back(10'h20C);
        exp_q.push_back(10'h201);
        exp_q.push_back(10'h206);
        wait_idle("rst_init_idle", INIT_WAIT_CYC + 3 * PERIOD_S + PERIOD_L + 50);
        check("rst_init_pulses", pulse_cnt - p0, 4);
`else
        repeat (3 * PERIOD_S) @(negedge clk);
        check("rst_no_pulses", pulse_cnt - p0, 0);
        check("rst_idle_busy", {31'h0, busy}, 32'h0);
`endif
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
